// File: rtl/boot_loader_pkg.sv
// Shared definitions for the flash-to-ITCM boot loader.
package boot_loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      CMD,
      ADDR_HI,
      ADDR_MID,
      ADDR_LO,
      READ,
      WRITE,
      DONE,
      ERROR
   } state_t;

   localparam int unsigned ITCM_ADDR_W    = 12;
   localparam logic [7:0]  FLASH_CMD_READ = 8'h03;
   localparam logic [7:0]  FLASH_DUMMY    = 8'h00;
   localparam logic [31:0] BLANK_ONES     = 32'hFFFF_FFFF;
   localparam logic [31:0] BLANK_ZEROS    = 32'h0000_0000;

   // States that own one outstanding SPI byte exchange.
   function automatic logic is_byte_state(input state_t s);
      return s inside {CMD, ADDR_HI, ADDR_MID, ADDR_LO, READ};
   endfunction

   // Erased (all ones) or zero-filled flash word.
   function automatic logic is_blank(input logic [31:0] w);
      return (w == BLANK_ONES) || (w == BLANK_ZEROS);
   endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Byte-to-word shift register: first byte received lands in bits [7:0].
module boot_word_assembler
   import boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic [1:0]  byte_cnt,
   output logic        word_valid
);

   // Shift bytes in from the top; word_valid pulses the cycle the 4th byte lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word       <= '0;
         byte_cnt   <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= byte_valid && (byte_cnt == 2'd3);
         if (byte_valid) begin
            word     <= {byte_in, word[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
         end
      end
   end

endmodule

// File: rtl/boot_loader.sv
// Copies WORD_COUNT words from SPI flash into ITCM, then releases core reset.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int unsigned WORD_COUNT = 1024,
   parameter logic [23:0] FLASH_BASE = 24'h000000
) (
   input  logic        clk,
   input  logic        cpu_rst,
   output logic        spi_start,
   output logic [7:0]  spi_tx,
   input  logic        spi_done,
   input  logic [7:0]  spi_rx,
   output logic        spi_cs,
   output logic        itcm_we,
   output logic [11:0] itcm_addr,
   output logic [31:0] itcm_wdata,
   output logic        core_rst_n,
   output logic        boot_error
);

   localparam int unsigned IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

   state_t                  state;
   logic [IDX_W-1:0]        word_index;
   logic                    ld_we;
   logic [ITCM_ADDR_W-1:0]  ld_addr;
   logic [31:0]             asm_word;
   logic [1:0]              asm_byte_cnt;
   logic                    asm_word_valid;
   logic                    rx_take_c;

   // A completion counts only in a byte state once its start pulse has gone out.
   assign rx_take_c = spi_done && !spi_start && is_byte_state(state);

   boot_word_assembler u_asm (
      .clk        (clk),
      .rst_n      (cpu_rst),
      .byte_valid (rx_take_c && (state == READ)),
      .byte_in    (spi_rx),
      .word       (asm_word),
      .byte_cnt   (asm_byte_cnt),
      .word_valid (asm_word_valid)
   );

   // Load sequencer: command, address, then word reads with one write per word.
   always_ff @(posedge clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         state      <= IDLE;
         spi_start  <= 1'b0;
         spi_tx     <= '0;
         spi_cs     <= 1'b1;
         ld_we      <= 1'b0;
         ld_addr    <= '0;
         core_rst_n <= 1'b0;
         boot_error <= 1'b0;
         word_index <= '0;
      end else begin
         spi_start <= 1'b0;
         case (state)
            IDLE: begin
               state     <= CMD;
               spi_cs    <= 1'b0;
               spi_start <= 1'b1;
               spi_tx    <= FLASH_CMD_READ;
            end
            CMD: if (rx_take_c) begin
               state     <= ADDR_HI;
               spi_start <= 1'b1;
               spi_tx    <= FLASH_BASE[23:16];
            end
            ADDR_HI: if (rx_take_c) begin
               state     <= ADDR_MID;
               spi_start <= 1'b1;
               spi_tx    <= FLASH_BASE[15:8];
            end
            ADDR_MID: if (rx_take_c) begin
               state     <= ADDR_LO;
               spi_start <= 1'b1;
               spi_tx    <= FLASH_BASE[7:0];
            end
            ADDR_LO: if (rx_take_c) begin
               state     <= READ;
               spi_start <= 1'b1;
               spi_tx    <= FLASH_DUMMY;
            end
            READ: if (rx_take_c) begin
               if (asm_byte_cnt == 2'd3) begin
                  state   <= WRITE;
                  ld_we   <= 1'b1;
                  ld_addr <= ITCM_ADDR_W'(word_index) << 2;
               end else begin
                  spi_start <= 1'b1;
                  spi_tx    <= FLASH_DUMMY;
               end
            end
            WRITE: if (asm_word_valid) begin
               ld_we <= 1'b0;
               if ((word_index == '0) && is_blank(asm_word)) begin
                  state      <= ERROR;
                  spi_cs     <= 1'b1;
                  boot_error <= 1'b1;
               end else if (word_index == LAST_IDX) begin
                  state      <= DONE;
                  spi_cs     <= 1'b1;
                  core_rst_n <= 1'b1;
               end else begin
                  word_index <= word_index + IDX_W'(1);
                  state      <= READ;
                  spi_start  <= 1'b1;
                  spi_tx     <= FLASH_DUMMY;
               end
            end
            DONE:    state <= DONE;
            ERROR:   state <= ERROR;
            default: state <= IDLE;
         endcase
      end
   end

   // ITCM port belongs to the loader only while the core is held in reset.
   assign itcm_we    = ld_we & ~core_rst_n;
   assign itcm_addr  = core_rst_n ? '0 : ld_addr;
   assign itcm_wdata = core_rst_n ? '0 : asm_word;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader with a behavioural SPI flash responder.
module tb_boot_loader;

   localparam int unsigned WC   = 4;
   localparam logic [23:0] BASE = 24'h012345;
   localparam int unsigned NB   = 4 * WC;
   localparam int          BUDGET = 4000;

   logic        clk = 1'b0;
   logic        cpu_rst = 1'b0;
   logic        spi_start;
   logic [7:0]  spi_tx;
   logic        spi_done;
   logic        resp_done;
   logic        stray_done;
   logic [7:0]  spi_rx;
   logic        spi_cs;
   logic        itcm_we;
   logic [11:0] itcm_addr;
   logic [31:0] itcm_wdata;
   logic        core_rst_n;
   logic        boot_error;

   assign spi_done = resp_done | stray_done;

   boot_loader #(.WORD_COUNT(WC), .FLASH_BASE(BASE)) dut (
      .clk        (clk),
      .cpu_rst    (cpu_rst),
      .spi_start  (spi_start),
      .spi_tx     (spi_tx),
      .spi_done   (spi_done),
      .spi_rx     (spi_rx),
      .spi_cs     (spi_cs),
      .itcm_we    (itcm_we),
      .itcm_addr  (itcm_addr),
      .itcm_wdata (itcm_wdata),
      .core_rst_n (core_rst_n),
      .boot_error (boot_error)
   );

   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Flash image and responder: exchange n>=4 returns image byte n-4.
   logic [7:0] img [NB];
   int dmode = 0;
   int xch;

   function automatic int pick_delay();
      int r;
      if (dmode == 0) return 0;
      r = int'($urandom_range(0, 2));
      return (r == 0) ? 0 : (r == 1) ? 1 : 37;
   endfunction

   initial begin
      resp_done = 1'b0;
      spi_rx    = 8'h00;
      xch       = 0;
      forever begin
         @(posedge clk); #1;
         if (!cpu_rst) xch = 0;
         while (spi_start && cpu_rst) begin
            int d;
            logic [7:0] b;
            d = pick_delay();
            b = (xch >= 4 && xch < 4 + int'(NB)) ? img[xch - 4] : 8'($urandom);
            xch++;
            @(posedge clk); #1;
            for (int k = 0; k < d && cpu_rst; k++) begin
               @(posedge clk); #1;
            end
            if (cpu_rst) begin
               resp_done = 1'b1;
               spi_rx    = b;
               @(posedge clk); #1;
               resp_done = 1'b0;
            end
         end
      end
   end

   // Bus monitor, sampled on the falling edge.
   typedef struct packed { logic [11:0] addr; logic [31:0] data; } wr_t;
   wr_t        wr_q[$];
   logic [7:0] tx_q[$];
   int         n_start, n_done, n_overlap;
   logic       outst;

   always @(negedge clk) begin
      if (!cpu_rst) begin
         wr_q.delete();
         tx_q.delete();
         n_start = 0; n_done = 0; n_overlap = 0; outst = 1'b0;
      end else begin
         if (spi_start) begin
            if (outst) n_overlap++;
            outst = 1'b1;
            n_start++;
            tx_q.push_back(spi_tx);
         end
         if (spi_done) begin
            n_done++;
            outst = 1'b0;
         end
         if (itcm_we) wr_q.push_back({itcm_addr, itcm_wdata});
      end
   end

   // Reference model: little-endian words, blank word 0 stops after one write.
   function automatic logic [31:0] exp_word(input int i);
      return {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
   endfunction

   function automatic int exp_nwr();
      logic [31:0] w0;
      w0 = exp_word(0);
      return (w0 == 32'hFFFF_FFFF || w0 == 32'h0) ? 1 : int'(WC);
   endfunction

   function automatic logic [7:0] exp_tx(input int n);
      logic [23:0] a;
      a = BASE;
      if (n == 0) return 8'h03;
      if (n < 4)  return 8'(a >> (8 * (3 - n)));
      return 8'h00;
   endfunction

   function automatic void fill_img(input int kind);
      for (int i = 0; i < int'(NB); i++) begin
         case (kind)
            3:       img[i] = 8'($urandom);
            default: img[i] = 8'(i + 1);
         endcase
      end
      case (kind)
         1: for (int i = 0; i < 4; i++) img[i] = 8'hFF;
         2: for (int i = 0; i < 4; i++) img[i] = 8'h00;
         3: img[0] = 8'h5A;
         4: begin img[0] = 8'hFE; img[1] = 8'hFF; img[2] = 8'hFF; img[3] = 8'hFF; end
         default: ;
      endcase
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rst_start"}, 32'(spi_start), 0);
      chk({tag, "_rst_tx"},    32'(spi_tx), 0);
      chk({tag, "_rst_cs"},    32'(spi_cs), 1);
      chk({tag, "_rst_itcm"},  {19'(itcm_addr), 12'(itcm_wdata[11:0]), itcm_we}, 0);
      chk({tag, "_rst_wdata"}, itcm_wdata, 0);
      chk({tag, "_rst_core"},  {30'(0), core_rst_n, boot_error}, 0);
   endtask

   task automatic reset_and_release(input string tag);
      @(posedge clk); #2 cpu_rst = 1'b0;
      #1 chk_reset_outputs(tag);
      repeat (3) @(posedge clk);
      #2 cpu_rst = 1'b1;
   endtask

   task automatic wait_end(input string tag);
      int cyc;
      cyc = 0;
      while (!(core_rst_n || boot_error) && cyc < BUDGET) begin
         @(posedge clk);
         cyc++;
      end
      chk({tag, "_finished"}, 32'(cyc < BUDGET), 1);
      repeat (5) @(negedge clk);
   endtask

   task automatic compare_results(input string tag, input logic e_err, input logic e_core);
      int nwr, ntx;
      nwr = exp_nwr();
      ntx = 4 + 4 * nwr;
      chk({tag, "_boot_error"}, 32'(boot_error), 32'(e_err));
      chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(e_core));
      chk({tag, "_spi_cs"},     32'(spi_cs), 1);
      chk({tag, "_n_writes"},   32'(wr_q.size()), 32'(nwr));
      for (int i = 0; i < nwr && i < wr_q.size(); i++) begin
         chk($sformatf("%s_wr%0d_addr", tag, i), 32'(wr_q[i].addr), 32'(i * 4));
         chk($sformatf("%s_wr%0d_data", tag, i), wr_q[i].data, exp_word(i));
      end
      chk({tag, "_n_tx"}, 32'(tx_q.size()), 32'(ntx));
      for (int n = 0; n < ntx && n < tx_q.size(); n++)
         chk($sformatf("%s_tx%0d", tag, n), 32'(tx_q[n]), 32'(exp_tx(n)));
      chk({tag, "_start_eq_done"}, 32'(n_start), 32'(n_done));
      chk({tag, "_overlap"}, 32'(n_overlap), 0);
   endtask

   typedef struct {
      int   kind;
      int   dmode;
      logic exp_err;
      logic exp_core;
   } vec_t;

   vec_t vecs[6];

   initial begin
      stray_done = 1'b0;
      vecs[0] = '{0, 0, 1'b0, 1'b1};
      vecs[1] = '{0, 1, 1'b0, 1'b1};
      vecs[2] = '{1, 0, 1'b1, 1'b0};
      vecs[3] = '{2, 1, 1'b1, 1'b0};
      vecs[4] = '{3, 1, 1'b0, 1'b1};
      vecs[5] = '{4, 1, 1'b0, 1'b1};

      for (int v = 0; v < 6; v++) begin
         string tag;
         tag = $sformatf("v%0d", v);
         fill_img(vecs[v].kind);
         dmode = vecs[v].dmode;
         reset_and_release(tag);
         wait_end(tag);
         compare_results(tag, vecs[v].exp_err, vecs[v].exp_core);
      end

      // Reset after the 2nd byte of word 1, then full reload.
      begin
         int cyc;
         fill_img(0);
         dmode = 1;
         reset_and_release("mid");
         cyc = 0;
         while (n_done < 10 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
         end
         chk("mid_reached_word1", 32'(cyc < BUDGET), 1);
         #1 cpu_rst = 1'b0;
         #1 chk_reset_outputs("mid_abort");
         repeat (3) @(posedge clk);
         #2 cpu_rst = 1'b1;
         wait_end("mid_reload");
         compare_results("mid_reload", 1'b0, 1'b1);
      end

      // Stray completion while terminal in DONE must be ignored.
      fill_img(0);
      dmode = 0;
      reset_and_release("stray");
      wait_end("stray");
      @(posedge clk); #1 stray_done = 1'b1;
      @(posedge clk); #1 stray_done = 1'b0;
      repeat (4) @(negedge clk);
      chk("stray_n_start",  32'(n_start), 32'(4 + 4 * WC));
      chk("stray_n_writes", 32'(wr_q.size()), 32'(WC));
      chk("stray_outputs",  {28'(0), spi_cs, core_rst_n, boot_error, itcm_we}, 32'b1100);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
